// File: rtl/vga_pkg.sv
// Shared constants and enums for the VRAM arbiter slice: window geometry,
// slot tags carried down the read pipeline, and the clear-engine FSM states.
package vga_pkg;

    localparam int FB_W      = 488;
    localparam int FB_H      = 280;
    localparam int FB_PIXELS = FB_W * FB_H;
    localparam int ADDR_W    = 18;
    localparam int COLOR_W   = 12;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2
    } slot_tag_t;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/vram_req_fifo.sv
// In-order request queue for the CPU port of the VRAM arbiter.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module vram_req_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: never-stalled display scan-out plus a queued CPU port.
// Optional fill engine is compiled in with `define VRAM_CLEAR_EN.
module vram_arbiter #(
    parameter int FB_W    = 488,
    parameter int FB_H    = 280,
    parameter int ADDR_W  = 18,
    parameter int COLOR_W = 12,
    parameter int QDEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [10:0]        pix_x,
    input  logic [10:0]        pix_y,
    output logic [COLOR_W-1:0] pix_color,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [COLOR_W-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic [COLOR_W-1:0] cpu_rdata,
    output logic               cpu_rvalid,
`ifdef VRAM_CLEAR_EN
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_busy,
`endif
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata
);

    import vga_pkg::*;

    localparam int NPIX = FB_W * FB_H;
    localparam int EW   = 1 + ADDR_W + COLOR_W;
    localparam int CW   = $clog2(QDEPTH + 1);

    logic               disp_go, clr_go, cpu_go, clr_run;
    logic [ADDR_W-1:0]  disp_addr, clr_addr;
    logic [COLOR_W-1:0] clr_color_q;
    logic               enq, fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        next_count;
    logic [EW-1:0]      head;
    logic               head_we, head_oor;
    logic [ADDR_W-1:0]  head_addr;
    logic [COLOR_W-1:0] head_wdata;
    slot_tag_t          tag_p0, tag_p1;
    logic               zero_p0, zero_p1;

    assign disp_go   = pix_valid && (pix_x < 11'(FB_W)) && (pix_y < 11'(FB_H));
    assign disp_addr = ADDR_W'(pix_y) * ADDR_W'(FB_W) + ADDR_W'(pix_x);

    assign {head_we, head_addr, head_wdata} = head;
    assign head_oor = (head_addr >= ADDR_W'(NPIX));

    // Fixed priority: display, then clear engine, then CPU queue head.
    assign clr_go = !disp_go && clr_run;
    assign cpu_go = !disp_go && !clr_run && !fifo_empty;

    assign enq        = cpu_req && cpu_ack && !fifo_full;
    assign next_count = {1'b0, fifo_count} + (CW+1)'(enq) - (CW+1)'(cpu_go);

    vram_req_fifo #(
        .W     (EW),
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (enq),
        .din   ({cpu_we, cpu_addr, cpu_wdata}),
        .pop   (cpu_go),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef VRAM_CLEAR_EN
    clr_state_t clr_state;

    assign clr_run = (clr_state == CLR_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_state   <= CLR_IDLE;
            clr_addr    <= '0;
            clr_color_q <= '0;
            clear_busy  <= 1'b0;
        end else begin
            case (clr_state)
                CLR_IDLE: if (clear_req) begin
                    clr_state   <= CLR_RUN;
                    clr_addr    <= '0;
                    clr_color_q <= clear_color;
                    clear_busy  <= 1'b1;
                end
                CLR_RUN: if (clr_go) begin
                    if (clr_addr == ADDR_W'(NPIX - 1)) begin
                        clr_state  <= CLR_IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
            endcase
        end
    end
`else
    assign clr_run     = 1'b0;
    assign clr_addr    = '0;
    assign clr_color_q = '0;
`endif

    // Stage p0: slot grant registered onto the RAM port, tag launched.
    // Out-of-range CPU accesses never strobe the RAM; reads are flagged to return 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tag_p0    <= TAG_NONE;
            zero_p0   <= 1'b0;
            cpu_ack   <= 1'b0;
        end else begin
            mem_en    <= disp_go || clr_go || (cpu_go && !head_oor);
            mem_we    <= clr_go || (cpu_go && head_we && !head_oor);
            mem_addr  <= disp_go ? disp_addr : (clr_go ? clr_addr : head_addr);
            mem_wdata <= clr_go ? clr_color_q : head_wdata;
            tag_p0    <= disp_go ? TAG_DISP : ((cpu_go && !head_we) ? TAG_CPU : TAG_NONE);
            zero_p0   <= head_oor;
            cpu_ack   <= (next_count < (CW+1)'(QDEPTH));
        end
    end

    // Stage p1: tag aligned with mem_rdata; stage p2: route read data by tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_p1     <= TAG_NONE;
            zero_p1    <= 1'b0;
            pix_color  <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            tag_p1     <= tag_p0;
            zero_p1    <= zero_p0;
            pix_color  <= (tag_p1 == TAG_DISP) ? mem_rdata : '0;
            cpu_rvalid <= (tag_p1 == TAG_CPU);
            cpu_rdata  <= (tag_p1 == TAG_CPU && !zero_p1) ? mem_rdata : '0;
        end
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port, 1-cycle-latency video RAM between two users:
- **Display scan-out:** fixed-latency reads of the 488×280 window for the VGA timing generator.
- **CPU port:** queued, in-order reads and writes through a request/acknowledge handshake.

The block sits between the pipeline's memory-mapped display region and the VGA timing generator. It guarantees display reads are never stalled; CPU accesses use free slots only.

## Interface
Parameters:
- FB_W, 488, window width in pixels
- FB_H, 280, window height in lines
- ADDR_W, 18, RAM address width (covers FB_W*FB_H = 136640)
- COLOR_W, 12, pixel width (RRRRGGGGBBBB)
- QDEPTH, 4, CPU request queue depth (power of two)

Ports:
- clk  in  1  system clock (65 MHz)
- rst  in  1  asynchronous, active-low reset
- pix_valid  in  1  timing generator requests a pixel this cycle
- pix_x  in  11  window-relative x of requested pixel
- pix_y  in  11  window-relative y of requested pixel
- pix_color  out  COLOR_W  returned pixel, 0 when blank
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  linear pixel address
- cpu_wdata  in  COLOR_W  write data
- cpu_ack  out  1  queue can accept; transfer when cpu_req & cpu_ack
- cpu_rdata  out  COLOR_W  read data
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- mem_en, mem_we  out  1  RAM strobe / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  COLOR_W  RAM write data
- mem_rdata  in  COLOR_W  RAM read data, valid one cycle after mem_en

## Operation
- **Display address:** pix_y*FB_W + pix_x, ADDR_W bits. Constant multiply (488 = 512-16-8), no DSP required.
- **Out-of-window requests:** a request with pix_x ≥ FB_W or pix_y ≥ FB_H is treated as pix_valid = 0.
- **Slot arbitration, per cycle, fixed priority:**
  1. Display, when pix_valid is 1 and in range.
  2. Clear engine (see Configuration).
  3. Head of the CPU queue.
  4. Otherwise mem_en = 0.
- **Read tagging:** each granted slot carries a 2-bit tag (NONE, DISP, CPU) down a 2-stage pipeline alongside the RAM read. mem_rdata is routed by that tag.
- **CPU queue:** FIFO of {we, addr, wdata}, processed strictly in order.
  - cpu_ack = registered (next_count < QDEPTH).
  - Reads return exactly one cpu_rvalid pulse each, in issue order.
- **CPU address ≥ FB_W*FB_H:**
  - Write: dropped (no mem_en).
  - Read: still occupies its slot; returns cpu_rdata = 0 with cpu_rvalid.
- **Pixel output:** pix_color = 0 for any blank or out-of-range request.

## Timing
- **Reset values:** all outputs 0, including cpu_ack. Queue empty, tag pipeline NONE.
  - cpu_ack rises on the first clock edge after rst deasserts.
- **Display latency:** pix_valid sampled in cycle N → mem_* registered, visible in N+1 → mem_rdata in N+2 → pix_color visible in N+3. The latency is always exactly 3 cycles.
  - The timing generator issues window coordinates 3 cycles early.
- **CPU latency:**
  - Minimum: accepted at edge E; earliest grant is cycle E+1; cpu_rvalid at E+3.
  - Maximum: unbounded during a line's active window. Bounded by the horizontal blanking slack (≥ 312 free slots per 800-cycle line).
- **Queue full:** cpu_ack = 0; no enqueue. A same-cycle dequeue raises cpu_ack next cycle. There is no bypass.
- **Simultaneous enqueue + dequeue:** count unchanged.
- **Reset mid-operation:**
  - Queue flushed and in-flight tags discarded; no cpu_rvalid is emitted for dropped reads.
  - Clear aborted.

## Configuration
- **VRAM_CLEAR_EN defined:**
  - Adds inputs clear_req (pulse) and clear_color[COLOR_W-1:0], and output clear_busy.
  - FSM CLR_IDLE → CLR_RUN on clear_req; clear_color is latched at that point.
  - CLR_RUN writes addresses 0..FB_W*FB_H-1 using priority-2 slots. It returns to CLR_IDLE after writing the last address, and clear_busy drops on the same edge.
  - clear_req while busy is ignored.
  - The CPU queue still accepts entries during CLR_RUN but does not drain until the clear completes.
- **VRAM_CLEAR_EN undefined:** ports absent; slot priority is display then CPU.

## Structure
- **Package vga_pkg:** FB_W, FB_H, FB_PIXELS, ADDR_W, COLOR_W, the slot-tag enum {TAG_NONE, TAG_DISP, TAG_CPU}, and the clear FSM state enum.
- **Sub-module vram_req_fifo:** synchronous FIFO (QDEPTH × (1 + ADDR_W + COLOR_W)) with count, full, empty; same clk/rst.

## Test plan
- **Reset:** hold rst low 5 cycles, release → all outputs 0; cpu_ack = 1 one edge after release.
- **Display read:** preload addr 489 = 0xABC; pix_valid, x=1, y=1 → mem_addr = 489 next cycle; pix_color = 0xABC exactly 3 cycles after request.
- **CPU write then read:** write 0x123 to addr 5 with pix_valid = 0, then read addr 5 → cpu_rvalid with 0x123, in order; mem_we seen once.
- **Contention:** pix_valid held 488 cycles while CPU enqueues 5 requests → cpu_ack drops after 4; no CPU mem_en during the window; all 4 drain in the first 4 blank cycles.
- **Out of range:** pix_x = 500 → pix_color = 0, no mem_en. CPU read addr 200000 → cpu_rdata = 0 with cpu_rvalid.
- **Clear (VRAM_CLEAR_EN):** clear_req with color 0xF00 → clear_busy for ≥ 136640 cycles; every address reads 0xF00; a CPU write queued mid-clear lands after it.
